// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and writeback request type for the CPU writeback slice
package cpu_pkg;

    localparam int XLEN       = 64;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    // One pending register-file write: destination register and its value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests with a registered ready flag
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   push_valid   source offers push_req this cycle
//   push_ready   registered "queue not full"; 0 while in reset
//   push_req     entry pushed when push_valid && push_ready
//   pop          consumer removes the head entry (ignored when empty)
//   head         current head entry
//   empty        queue holds no entries
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_valid,
    output logic    push_ready,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          do_pop;

    assign push       = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(do_pop);
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr];

    // Ready is the not-full flag computed from the next occupancy and then
    // registered, so a pop never opens the queue within the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            push_ready <= (count_next != (AW+1)'(DEPTH));
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_req;
        end
    end

endmodule

// File: rtl/cpu_writeback.sv
// rtl/cpu_writeback.sv - two-source writeback arbiter with register-file write port and busy scoreboard
//
// Ports:
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   alu_valid/ready/addr/data       ALU result stream into its queue
//   mem_valid/ready/addr/data       load result stream into its queue
//   issue_valid, issue_addr         issued instruction marks its destination busy
//   write_enable/addr/data          registered register-file write port
//   busy                            one pending-write bit per register
module cpu_writeback
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = cpu_pkg::XLEN,
    parameter int NREGS      = cpu_pkg::NREGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [XLEN-1:0]       write_data,
    output logic [NREGS-1:0]      busy
);

    wb_req_t          alu_req;
    wb_req_t          mem_req;
    wb_req_t          alu_head;
    wb_req_t          mem_head;
    logic             alu_empty;
    logic             mem_empty;
    logic             pop_alu;
    logic             pop_mem;
    logic             last_mem;
    logic [NREGS-1:0] busy_next;

    assign alu_req = '{addr: alu_addr, data: alu_data};
    assign mem_req = '{addr: mem_addr, data: mem_data};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (alu_valid),
        .push_ready (alu_ready),
        .push_req   (alu_req),
        .pop        (pop_alu),
        .head       (alu_head),
        .empty      (alu_empty)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (mem_valid),
        .push_ready (mem_ready),
        .push_req   (mem_req),
        .pop        (pop_mem),
        .head       (mem_head),
        .empty      (mem_empty)
    );

    // last_mem records the most recent grant; when both queues hold entries
    // the other source wins. Reset value 1 makes ALU the first winner.
    always_comb begin
        pop_alu = 1'b0;
        pop_mem = 1'b0;
        if (!alu_empty && (mem_empty || last_mem)) begin
            pop_alu = 1'b1;
        end else if (!mem_empty) begin
            pop_mem = 1'b1;
        end
    end

    // Clear for the write retiring now, then set for a new issue so that a
    // same-register collision leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (write_enable) begin
            busy_next[write_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            busy         <= '0;
            last_mem     <= 1'b1;
        end else begin
            write_enable <= pop_alu || pop_mem;
            if (pop_alu) begin
                write_addr <= alu_head.addr;
                write_data <= alu_head.data;
                last_mem   <= 1'b0;
            end else if (pop_mem) begin
                write_addr <= mem_head.addr;
                write_data <= mem_head.data;
                last_mem   <= 1'b1;
            end
            busy <= busy_next;
        end
    end

endmodule

// File: doc/cpu_writeback.md
CPU_WRITEBACK -- requirements
Module: cpu_writeback

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, entries per source result queue (power of two, at least 2).
REQ-002 Parameter XLEN, default 64, result data width.
REQ-003 Parameter NREGS, default 32, architectural register count; the address width is 5.
REQ-004 The block SHALL use one clock, clk, and reset, rst, with synchronous active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 alu_valid  input  1  ALU result offered.
REQ-008 alu_ready  output  1  ALU queue can accept.
REQ-009 alu_addr  input  5  ALU destination register.
REQ-010 alu_data  input  XLEN  ALU result value.
REQ-011 mem_valid  input  1  load result offered.
REQ-012 mem_ready  output  1  load queue can accept.
REQ-013 mem_addr  input  5  load destination register.
REQ-014 mem_data  input  XLEN  load result value.
REQ-015 issue_valid  input  1  an instruction with a destination is issued this cycle.
REQ-016 issue_addr  input  5  destination register of that issued instruction.
REQ-017 write_enable  output  1  register-file write strobe.
REQ-018 write_addr  output  5  register-file write address.
REQ-019 write_data  output  XLEN  register-file write data.
REQ-020 busy  output  NREGS  pending-write scoreboard, one bit per register.

Function
REQ-021 A source handshake SHALL complete on a cycle where valid and ready are both 1; {addr, data} is pushed into that source's queue.
REQ-022 Ready SHALL be driven from registered state only and SHALL equal "queue not full", with no combinational path from valid.
REQ-023 A pop in the same cycle SHALL NOT raise ready in that cycle; a full queue accepts again on the following cycle.
REQ-024 Each cycle, if at least one queue is non-empty, the arbiter SHALL pop exactly one head entry.
REQ-025 When only one queue is non-empty, the arbiter SHALL grant that queue.
REQ-026 When both queues are non-empty, the arbiter SHALL grant the source not granted last (round-robin); the pointer updates only on a grant.
REQ-027 The popped entry SHALL appear on write_enable=1, write_addr and write_data exactly one cycle after the pop.
REQ-028 Minimum latency from handshake to write_enable SHALL be 2 cycles.
REQ-029 When no entry is popped, write_enable SHALL be 0 next cycle and write_addr and write_data SHALL hold their previous values.
REQ-030 Order within one source SHALL be preserved.
REQ-031 No ordering between sources is guaranteed beyond REQ-026.
REQ-032 Address 0 SHALL be written like any other register, with no special case.
REQ-033 The busy bit busy[issue_addr] SHALL be set on the cycle after issue_valid=1.
REQ-034 The busy bit busy[write_addr] SHALL be cleared on the cycle after write_enable=1.
REQ-035 When a set and a clear of the same register occur in the same cycle, the set SHALL win.
REQ-036 Issuing to an already-busy register SHALL leave the bit set; there is no counting, and a single outstanding producer per register is the issuer's obligation.
REQ-037 A push to a full queue is impossible by construction (ready=0); if valid is held, the result SHALL stay pending at the source.

Reset
REQ-038 While rst=1 on a clock edge, both queues SHALL empty and alu_ready/mem_ready SHALL be 0.
REQ-039 On that reset edge, write_enable, write_addr, write_data and busy SHALL all be 0, and the round-robin pointer SHALL favour ALU.
REQ-040 Reset SHALL discard in-flight queued results and pending writes without producing a write.
REQ-041 alu_ready/mem_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-042 A shared package cpu_pkg SHALL hold XLEN, NREGS, REG_ADDR_W=5 and typedef wb_req_t {addr, data}.
REQ-043 A sub-module wb_fifo (a parameterised synchronous FIFO of wb_req_t with full/empty) SHALL be instantiated once per source.
REQ-044 Arbiter, scoreboard and output registers SHALL reside in cpu_writeback.

Verification
REQ-045 Single ALU result: ALU pushes addr 5, data 0xAA at cycle 0 -> write_enable=1, write_addr=5, write_data=0xAA at cycle 2, then 0 at cycle 3.
REQ-046 Simultaneous sources: ALU (addr 1, 0x11) and MEM (addr 2, 0x22) both push at cycle 0 after reset -> addr 1 written at cycle 2, addr 2 at cycle 3.
REQ-047 Backpressure: FIFO_DEPTH=2, MEM pushes 3 back-to-back while ALU streams continuously -> mem_ready=0 after the 2nd push, and all 3 MEM writes complete in push order, interleaved with ALU writes.
REQ-048 Scoreboard collision: issue addr 7 at cycle 0 -> busy[7]=1 at cycle 1; a write to 7 coinciding with a new issue to 7 -> busy[7] stays 1.
REQ-049 Reset mid-operation: rst=1 with both queues holding 2 entries -> no write_enable pulse, busy=0, and readies return to 1 one cycle after rst=0.
